// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with bypass, scoreboard and accelerator writeback port
//
// Purpose: general-purpose register file. Register 0 is hard-wired to zero.
// The core writeback port and a handshaked accelerator port write the array.
// The core port always wins, so ACC_READY drops whenever the core writes a
// real register. A BUSY scoreboard marks registers reserved for pending
// accelerator results. Read ports are registered and see the state after the
// same edge's updates, so a write and a read in one cycle need no bubble.
//
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   RADDR / RDATA / RBUSY NREAD packed read ports (address, data, busy bit)
//   WE, WADDR, WDATA      core writeback
//   RSV_VALID, RSV_ADDR   scoreboard reservation
//   ACC_VALID/ADDR/DATA   accelerator result, ACC_READY accepts it
//   BUSY                  scoreboard vector
//   LED                   low byte of register LED_REG (stored value)
module regfile_mp #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int AW      = $clog2(NREGS),
  parameter int NREAD   = 2,
  parameter int LED_REG = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREAD*AW-1:0]   RADDR,
  output logic [NREAD*XLEN-1:0] RDATA,
  output logic [NREAD-1:0]      RBUSY,
  input  logic                  WE,
  input  logic [AW-1:0]         WADDR,
  input  logic [XLEN-1:0]       WDATA,
  input  logic                  RSV_VALID,
  input  logic [AW-1:0]         RSV_ADDR,
  input  logic                  ACC_VALID,
  input  logic [AW-1:0]         ACC_ADDR,
  input  logic [XLEN-1:0]       ACC_DATA,
  output logic                  ACC_READY,
  output logic [NREGS-1:0]      BUSY,
  output logic [7:0]            LED
);

  logic [XLEN-1:0]       regs_q [NREGS];
  logic [XLEN-1:0]       regs_d [NREGS];
  logic [NREGS-1:0]      busy_q, busy_d;
  logic [NREAD*XLEN-1:0] rdata_q, rdata_d;
  logic [NREAD-1:0]      rbusy_q, rbusy_d;
  logic                  core_wr;
  logic                  acc_accept;

  // Core writes to r0 do not block the accelerator.
  assign core_wr    = WE && (WADDR != '0);
  assign ACC_READY  = !RST && !core_wr;
  assign acc_accept = ACC_VALID && ACC_READY;

  // Next register state. An accepted accelerator write can never coincide
  // with a core write because of the ready gating above.
  always_comb begin
    regs_d = regs_q;
    if (core_wr) begin
      regs_d[WADDR] = WDATA;
    end else if (acc_accept && (ACC_ADDR != '0)) begin
      regs_d[ACC_ADDR] = ACC_DATA;
    end
    regs_d[0] = '0;
  end

  // Scoreboard: clear on accept first, then set, so a same-cycle reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (acc_accept) begin
      busy_d[ACC_ADDR] = 1'b0;
    end
    if (RSV_VALID && (RSV_ADDR != '0)) begin
      busy_d[RSV_ADDR] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Reads look at next state, which gives write-through bypass for free.
  always_comb begin
    logic [AW-1:0] ra;
    ra      = '0;
    rdata_d = '0;
    rbusy_d = '0;
    for (int i = 0; i < NREAD; i++) begin
      ra                       = RADDR[i*AW +: AW];
      rdata_d[i*XLEN +: XLEN]  = regs_d[ra];
      rbusy_d[i]               = busy_d[ra];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int n = 0; n < NREGS; n++) begin
        regs_q[n] <= '0;
      end
      busy_q  <= '0;
      rdata_q <= '0;
      rbusy_q <= '0;
    end else begin
      for (int n = 0; n < NREGS; n++) begin
        regs_q[n] <= regs_d[n];
      end
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      rbusy_q <= rbusy_d;
    end
  end

  assign RDATA = rdata_q;
  assign RBUSY = rbusy_q;
  assign BUSY  = busy_q;
  assign LED   = regs_q[LED_REG][7:0];

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (default and 64/16/3 configurations)
//
// Purpose: drives one abstract stimulus stream into two instances (k=0: default
// parameters, k=1: XLEN=64, NREGS=16, NREAD=3) in lockstep. A directed vector
// table checks the plan's scenarios on the default instance; a reference model
// of the architectural register/scoreboard state checks both every cycle.
module tb_regfile_mp;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Abstract stimulus (widest form; each instance takes the low bits).
  logic        s_we;
  logic [4:0]  s_waddr;
  logic [63:0] s_wdata;
  logic        s_rsv;
  logic [4:0]  s_rsa;
  logic        s_av;
  logic [4:0]  s_aa;
  logic [63:0] s_ad;
  logic [4:0]  s_ra0, s_ra1, s_ra2;

  logic [63:0]  a_rdata;
  logic [1:0]   a_rbusy;
  logic         a_ready;
  logic [31:0]  a_busy;
  logic [7:0]   a_led;

  logic [191:0] b_rdata;
  logic [2:0]   b_rbusy;
  logic         b_ready;
  logic [15:0]  b_busy;
  logic [7:0]   b_led;

  regfile_mp dut_a (
    .CLK(CLK), .RST(RST),
    .RADDR({s_ra1, s_ra0}), .RDATA(a_rdata), .RBUSY(a_rbusy),
    .WE(s_we), .WADDR(s_waddr), .WDATA(s_wdata[31:0]),
    .RSV_VALID(s_rsv), .RSV_ADDR(s_rsa),
    .ACC_VALID(s_av), .ACC_ADDR(s_aa), .ACC_DATA(s_ad[31:0]),
    .ACC_READY(a_ready), .BUSY(a_busy), .LED(a_led)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NREAD(3)) dut_b (
    .CLK(CLK), .RST(RST),
    .RADDR({s_ra2[3:0], s_ra1[3:0], s_ra0[3:0]}), .RDATA(b_rdata), .RBUSY(b_rbusy),
    .WE(s_we), .WADDR(s_waddr[3:0]), .WDATA(s_wdata),
    .RSV_VALID(s_rsv), .RSV_ADDR(s_rsa[3:0]),
    .ACC_VALID(s_av), .ACC_ADDR(s_aa[3:0]), .ACC_DATA(s_ad),
    .ACC_READY(b_ready), .BUSY(b_busy), .LED(b_led)
  );

  // Reference state: architectural contents of each instance.
  logic [63:0] m_reg  [2][32];
  logic [31:0] m_busy [2];

  function automatic int nregs_of(input int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic int nread_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic logic [63:0] xmask_of(input int k);
    return (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] dut_rdata(input int k, input int i);
    if (k == 0) return {32'b0, a_rdata[i*32 +: 32]};
    return b_rdata[i*64 +: 64];
  endfunction

  function automatic logic dut_rbusy(input int k, input int i);
    if (k == 0) return a_rbusy[i];
    return b_rbusy[i];
  endfunction

  function automatic logic [31:0] dut_busy(input int k);
    if (k == 0) return a_busy;
    return {16'b0, b_busy};
  endfunction

  function automatic logic [7:0] dut_led(input int k);
    return (k == 0) ? a_led : b_led;
  endfunction

  function automatic logic dut_ready(input int k);
    return (k == 0) ? a_ready : b_ready;
  endfunction

  function automatic int sra(input int i);
    if (i == 0) return int'(s_ra0);
    if (i == 1) return int'(s_ra1);
    return int'(s_ra2);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 32; n++) m_reg[k][n] = '0;
      m_busy[k] = '0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < nread_of(k); i++) begin
        chk($sformatf("%s_rdata k%0d p%0d", tag, k, i), dut_rdata(k, i), 64'h0);
        chk($sformatf("%s_rbusy k%0d p%0d", tag, k, i), {63'b0, dut_rbusy(k, i)}, 64'h0);
      end
      chk($sformatf("%s_busy k%0d", tag, k), {32'b0, dut_busy(k)}, 64'h0);
      chk($sformatf("%s_led k%0d", tag, k), {56'b0, dut_led(k)}, 64'h0);
      chk($sformatf("%s_ready k%0d", tag, k), {63'b0, dut_ready(k)}, 64'h0);
    end
  endtask

  // One clock: check ACC_READY before the edge, predict from the rules, then
  // compare every registered output after the edge.
  task automatic step();
    logic [63:0] erd [2][3];
    logic        erb [2][3];
    logic        rdy, acc;
    logic [63:0] xm;
    int          msk, wa, rsa, aa, ra;
    #1;
    for (int k = 0; k < 2; k++) begin
      msk = nregs_of(k) - 1;
      xm  = xmask_of(k);
      wa  = int'(s_waddr) & msk;
      rsa = int'(s_rsa) & msk;
      aa  = int'(s_aa) & msk;
      rdy = !RST && (!s_we || wa == 0);
      acc = s_av && rdy;
      chk($sformatf("acc_ready k%0d", k), {63'b0, dut_ready(k)}, {63'b0, rdy});
      for (int i = 0; i < 3; i++) begin
        ra = sra(i) & msk;
        if (ra == 0)                    erd[k][i] = '0;
        else if (s_we && wa == ra)      erd[k][i] = s_wdata & xm;
        else if (acc && aa == ra)       erd[k][i] = s_ad & xm;
        else                            erd[k][i] = m_reg[k][ra];
      end
      if (s_we && wa != 0) m_reg[k][wa] = s_wdata & xm;
      if (acc && aa != 0)  m_reg[k][aa] = s_ad & xm;
      if (acc)             m_busy[k][aa] = 1'b0;
      if (s_rsv && rsa != 0) m_busy[k][rsa] = 1'b1;
      for (int i = 0; i < 3; i++) begin
        erb[k][i] = m_busy[k][sra(i) & msk];
      end
    end
    @(posedge CLK);
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < nread_of(k); i++) begin
        chk($sformatf("rdata k%0d p%0d", k, i), dut_rdata(k, i), erd[k][i]);
        chk($sformatf("rbusy k%0d p%0d", k, i), {63'b0, dut_rbusy(k, i)}, {63'b0, erb[k][i]});
      end
      chk($sformatf("busy k%0d", k), {32'b0, dut_busy(k)}, {32'b0, m_busy[k]});
      chk($sformatf("led k%0d", k), {56'b0, dut_led(k)}, {56'b0, m_reg[k][2][7:0]});
    end
  endtask

  task automatic idle();
    s_we = 0; s_waddr = 0; s_wdata = 0;
    s_rsv = 0; s_rsa = 0;
    s_av = 0; s_aa = 0; s_ad = 0;
    s_ra0 = 0; s_ra1 = 0; s_ra2 = 0;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rsv;
    logic [4:0]  rsa;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic [4:0]  r0, r1;
    logic [31:0] e_rd0, e_rd1;
    logic        e_rb0;
    logic        e_rdy;
    logic [7:0]  e_led;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                              input logic rsv, input logic [4:0] rsa,
                              input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic [4:0] r0, input logic [4:0] r1,
                              input logic [31:0] e_rd0, input logic [31:0] e_rd1,
                              input logic e_rb0, input logic e_rdy, input logic [7:0] e_led);
    vec_t v;
    v.we = we; v.waddr = waddr; v.wdata = wdata; v.rsv = rsv; v.rsa = rsa;
    v.av = av; v.aa = aa; v.ad = ad; v.r0 = r0; v.r1 = r1;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_rb0 = e_rb0; v.e_rdy = e_rdy; v.e_led = e_led;
    return v;
  endfunction

  vec_t tbl [14];

  initial begin
    logic pending;
    logic a_rdy_pre;

    //                we wa  wdata         rsv rsa av aa  adata         r0  r1  e_rd0         e_rd1         rb rdy led
    tbl[0]  = mk(1, 7,  32'h12345678, 0, 0,  0, 0,  32'h0,        7,  0,  32'h12345678, 32'h0,        0, 0, 8'h00);
    tbl[1]  = mk(1, 0,  32'hFFFFFFFF, 0, 0,  0, 0,  32'h0,        0,  7,  32'h0,        32'h12345678, 0, 1, 8'h00);
    tbl[2]  = mk(1, 2,  32'h000001C3, 0, 0,  0, 0,  32'h0,        2,  0,  32'h000001C3, 32'h0,        0, 0, 8'hC3);
    tbl[3]  = mk(0, 0,  32'h0,        1, 31, 0, 0,  32'h0,        31, 2,  32'h0,        32'h000001C3, 1, 1, 8'hC3);
    tbl[4]  = mk(1, 3,  32'h33,       0, 0,  1, 31, 32'hA5A5A5A5, 31, 3,  32'h0,        32'h33,       1, 0, 8'hC3);
    tbl[5]  = mk(1, 3,  32'h34,       0, 0,  1, 31, 32'hA5A5A5A5, 31, 3,  32'h0,        32'h34,       1, 0, 8'hC3);
    tbl[6]  = mk(0, 0,  32'h0,        0, 0,  1, 31, 32'hA5A5A5A5, 31, 3,  32'hA5A5A5A5, 32'h34,       0, 1, 8'hC3);
    tbl[7]  = mk(0, 0,  32'h0,        0, 0,  0, 0,  32'h0,        31, 3,  32'hA5A5A5A5, 32'h34,       0, 1, 8'hC3);
    tbl[8]  = mk(1, 0,  32'h0,        0, 0,  1, 5,  32'h77,       5,  31, 32'h77,       32'hA5A5A5A5, 0, 1, 8'hC3);
    tbl[9]  = mk(0, 0,  32'h0,        1, 9,  1, 9,  32'h55,       9,  5,  32'h55,       32'h77,       1, 1, 8'hC3);
    tbl[10] = mk(0, 0,  32'h0,        1, 10, 0, 0,  32'h0,        10, 9,  32'h0,        32'h55,       1, 1, 8'hC3);
    tbl[11] = mk(1, 10, 32'h1010,     0, 0,  0, 0,  32'h0,        10, 9,  32'h1010,     32'h55,       1, 0, 8'hC3);
    tbl[12] = mk(0, 0,  32'h0,        0, 0,  1, 0,  32'hDEAD,     0,  10, 32'h0,        32'h1010,     0, 1, 8'hC3);
    tbl[13] = mk(0, 0,  32'h0,        1, 0,  0, 0,  32'h0,        0,  31, 32'h0,        32'hA5A5A5A5, 0, 1, 8'hC3);

    idle();
    model_reset();
    RST = 1'b1;
    #2;
    check_all_zero("por");
    #6 RST = 1'b0;
    @(posedge CLK);
    #1;

    // Directed vectors.
    for (int v = 0; v < 14; v++) begin
      s_we = tbl[v].we; s_waddr = tbl[v].waddr; s_wdata = {32'b0, tbl[v].wdata};
      s_rsv = tbl[v].rsv; s_rsa = tbl[v].rsa;
      s_av = tbl[v].av; s_aa = tbl[v].aa; s_ad = {32'b0, tbl[v].ad};
      s_ra0 = tbl[v].r0; s_ra1 = tbl[v].r1; s_ra2 = tbl[v].r0;
      #1;
      chk($sformatf("vec%0d ready", v), {63'b0, a_ready}, {63'b0, tbl[v].e_rdy});
      step();
      chk($sformatf("vec%0d rdata0", v), {32'b0, a_rdata[31:0]},  {32'b0, tbl[v].e_rd0});
      chk($sformatf("vec%0d rdata1", v), {32'b0, a_rdata[63:32]}, {32'b0, tbl[v].e_rd1});
      chk($sformatf("vec%0d rbusy0", v), {63'b0, a_rbusy[0]},     {63'b0, tbl[v].e_rb0});
      chk($sformatf("vec%0d led", v),    {56'b0, a_led},          {56'b0, tbl[v].e_led});
    end
    chk("collide busy9", {63'b0, a_busy[9]}, 64'h1);
    chk("corewr busy10", {63'b0, a_busy[10]}, 64'h1);

    // Asynchronous reset in mid-cycle with live state (r9/r10 busy, r5 written).
    idle();
    s_we = 1; s_waddr = 5; s_wdata = 64'hDEADBEEF; s_ra0 = 5;
    step();
    chk("r5 before reset", {32'b0, a_rdata[31:0]}, 64'hDEADBEEF);
    idle();
    s_ra0 = 5; s_av = 1; s_aa = 6; s_ad = 64'h66;
    #3 RST = 1'b1;
    #1;
    check_all_zero("arst");
    @(posedge CLK);
    #1;
    check_all_zero("arst_hold");
    model_reset();
    #2 RST = 1'b0;
    s_av = 0;
    step();
    chk("r5 after reset", {32'b0, a_rdata[31:0]}, 64'h0);

    // Randomised traffic with a holding accelerator.
    pending = 0;
    for (int c = 0; c < 600; c++) begin
      s_we    = ($urandom_range(0, 9) < 4);
      s_waddr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      s_wdata = {$urandom, $urandom};
      s_rsv   = ($urandom_range(0, 9) < 3);
      s_rsa   = 5'($urandom_range(0, 31));
      if (!pending) begin
        s_av = ($urandom_range(0, 9) < 4);
        s_aa = 5'($urandom_range(0, 31));
        s_ad = {$urandom, $urandom};
      end
      s_ra0 = 5'($urandom_range(0, 31));
      s_ra1 = 5'($urandom_range(0, 31));
      s_ra2 = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) begin
        s_ra0 = s_waddr;
        s_ra1 = s_aa;
        s_ra2 = s_rsa;
      end
      a_rdy_pre = !s_we || (s_waddr == 0);
      step();
      pending = s_av && !a_rdy_pre;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
